logic_unit_pipe: RTL and testbench

//   Parametrised, registered successor to the single-bit gate primitives.

---
 rtl/logic_unit_pipe_if.sv | 28 ++
 rtl/logic_unit_pipe.sv | 71 +++++++
 tb/tb_logic_unit_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/op input and result output handshake bundle for logic_unit_pipe
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             acc_mode;
   logic             acc_clear;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             parity;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] txn_cnt;
   modport master (
      output in_valid, op, a, b, acc_mode, acc_clear, out_ready,
      input  in_ready, out_valid, y, zero, parity, acc, txn_cnt
   );
   modport slave (
      input  in_valid, op, a, b, acc_mode, acc_clear, out_ready,
      output in_ready, out_valid, y, zero, parity, acc, txn_cnt
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with one-deep valid/ready output stage,
// accumulator chaining and a wrapping accepted-transaction counter
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              reset,
   logic_unit_pipe_if.slave bus
);
   typedef enum logic [2:0] {
      OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_PASS
   } op_e;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] res;
   // ready depends only on the output stage so upstream never sees a combinational loop
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign a_eff        = bus.acc_clear ? '0 : (bus.acc_mode ? acc_q : bus.a);
   always_comb begin
      res = '0;
      case (op_e'(bus.op))
         OP_AND:  res = a_eff & bus.b;
         OP_OR:   res = a_eff | bus.b;
         OP_NOT:  res = ~a_eff;
         OP_XOR:  res = a_eff ^ bus.b;
         OP_NAND: res = ~(a_eff & bus.b);
         OP_NOR:  res = ~(a_eff | bus.b);
         OP_XNOR: res = ~(a_eff ^ bus.b);
         OP_PASS: res = bus.b;
      endcase
   end
   always_comb begin
      out_valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
      y_d         = accept ? res : y_q;
      zero_d      = accept ? ~|res : zero_q;
      parity_d    = accept ? ^res : parity_q;
      acc_d       = accept ? res : (bus.acc_clear ? '0 : acc_q);
      cnt_d       = accept ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b1;
         parity_q    <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         parity_q    <= parity_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.zero      = zero_q;
   assign bus.parity    = parity_q;
   assign bus.acc       = acc_q;
   assign bus.txn_cnt   = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: random and directed stimulus checked every cycle against a behavioural model
module tb_logic_unit_pipe;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   logic en = 1'b0;
   logic       m_v = 1'b0;
   logic [7:0] m_y = '0;
   logic [7:0] m_acc = '0;
   logic [7:0] m_cnt = '0;
   logic [7:0] m_r;
   logic       m_take;
   logic [7:0] c0;
   logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) bus ();
   logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [7:0] f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] z);
      case (op)
         3'd0: return x & z;
         3'd1: return x | z;
         3'd2: return ~x;
         3'd3: return x ^ z;
         3'd4: return ~(x & z);
         3'd5: return ~(x | z);
         3'd6: return ~(x ^ z);
         default: return z;
      endcase
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   assign m_take = bus.in_valid && (!m_v || bus.out_ready);
   assign m_r = f(bus.op, bus.acc_clear ? 8'h00 : (bus.acc_mode ? m_acc : bus.a), bus.b);
   always @(posedge clk) begin
      if (reset) begin
         en <= 1'b1;
         m_v <= 1'b0;
         m_y <= '0;
         m_acc <= '0;
         m_cnt <= '0;
      end else if (m_take) begin
         m_v <= 1'b1;
         m_y <= m_r;
         m_acc <= m_r;
         m_cnt <= m_cnt + 8'd1;
      end else begin
         if (bus.out_ready) m_v <= 1'b0;
         if (bus.acc_clear) m_acc <= '0;
      end
   end
   always @(negedge clk) begin
      if (en) begin
         chk("model out_valid", bus.out_valid, m_v);
         chk("model in_ready", bus.in_ready, !m_v || bus.out_ready);
         chk("model y", bus.y, m_y);
         chk("model zero", bus.zero, m_y == 8'h00);
         chk("model parity", bus.parity, ^m_y);
         chk("model acc", bus.acc, m_acc);
         chk("model txn_cnt", bus.txn_cnt, m_cnt);
      end
   end
   task automatic put(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic am, input logic ac, input logic ordy);
      bus.in_valid = v;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      bus.acc_mode = am;
      bus.acc_clear = ac;
      bus.out_ready = ordy;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask
   initial begin
      logic [7:0] sweep [8];
      sweep = '{8'h05, 8'hAF, 8'h5A, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h0F};
      put(0, 0, 0, 0, 0, 0, 0);
      do_reset();
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset y", bus.y, 0);
      chk("reset zero", bus.zero, 1);
      chk("reset acc", bus.acc, 0);
      chk("reset txn_cnt", bus.txn_cnt, 0);
      put(1, 3'd0, 8'hF0, 8'h3C, 0, 0, 1);
      tick();
      chk("and y", bus.y, 8'h30);
      chk("and out_valid", bus.out_valid, 1);
      chk("and zero", bus.zero, 0);
      chk("and parity", bus.parity, 0);
      for (int i = 0; i < 8; i++) begin
         put(1, 3'(i), 8'hA5, 8'h0F, 0, 0, 1);
         #1;
         chk("sweep in_ready", bus.in_ready, 1);
         tick();
         chk($sformatf("sweep op%0d y", i), bus.y, sweep[i]);
      end
      put(0, 0, 0, 0, 0, 0, 0);
      tick();
      c0 = bus.txn_cnt;
      put(1, 3'd3, 8'h01, 8'h01, 0, 0, 0);
      #1;
      chk("stall in_ready", bus.in_ready, 0);
      tick();
      chk("stall y", bus.y, 8'h0F);
      chk("stall txn_cnt", bus.txn_cnt, c0);
      bus.out_ready = 1'b1;
      tick();
      chk("release y", bus.y, 8'h00);
      chk("release zero", bus.zero, 1);
      chk("release txn_cnt", bus.txn_cnt, c0 + 8'd1);
      put(1, 3'd1, 8'h77, 8'h01, 0, 1, 1);
      tick();
      chk("acc1 y", bus.y, 8'h01);
      put(1, 3'd1, 8'h77, 8'h02, 1, 0, 1);
      tick();
      chk("acc2 y", bus.y, 8'h03);
      put(1, 3'd3, 8'h77, 8'hFF, 1, 0, 1);
      tick();
      chk("acc3 y", bus.y, 8'hFC);
      chk("acc3 acc", bus.acc, 8'hFC);
      for (int i = 0; i < 400; i++) begin
         put($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
         tick();
      end
      put(0, 0, 0, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 256; i++) begin
         put(1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0, 1);
         tick();
      end
      chk("wrap txn_cnt", bus.txn_cnt, 8'h00);
      put(1, 3'd7, 8'h00, 8'h3C, 0, 0, 1);
      tick();
      chk("wrap+1 txn_cnt", bus.txn_cnt, 8'h01);
      put(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("held out_valid", bus.out_valid, 1);
      put(1, 3'd0, 8'hFF, 8'hFF, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      put(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst y", bus.y, 0);
      chk("rst acc", bus.acc, 0);
      chk("rst txn_cnt", bus.txn_cnt, 0);
      chk("rst in_ready", bus.in_ready, 1);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
